// File: rtl/sys_time_sync_gen.sv
// 64-bit system tick counter locked to the EtherCAT SYNC0 pulse.
// Define SYS_TIME_SLEW_EN to correct small drift by rate slewing instead of hard jumps.
module sys_time_sync_gen #(
   parameter int SYNC_LAT = 3,
`ifdef SYS_TIME_SLEW_EN
   parameter int MAX_ERR  = 64,
`endif
   parameter int TO_MULT  = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        SYNC_IN,
   input  logic [63:0] SYNC_TIME,
   input  logic        SYNC_TIME_VALID,
   input  logic [31:0] SYNC_PERIOD,
   output logic [63:0] SYS_TIME,
   output logic        LOCKED,
   output logic        SYNC_PULSE,
   output logic        JUMP
);

   localparam int TO_W = 32 + $clog2(TO_MULT + 1);

   typedef enum logic [1:0] {S_FREE, S_ARMED, S_LOCKED} state_t;

   state_t          state_reg, state_next;
   logic [2:0]      sync_ff_reg;
   logic [63:0]     sys_time_reg, sys_time_next;
   logic [63:0]     cap_reg, cap_next;
   logic [63:0]     ref_reg, ref_next;
   logic [TO_W-1:0] timeout_reg, timeout_next;
   logic [TO_W-1:0] timeout_inc, timeout_lim;
   logic            pulse_reg;
   logic            jump_reg, jump_next;
   logic            sync_edge, period_zero, arm;
   logic [63:0]     sys_inc, lock_time;

   assign sync_edge   = (sync_ff_reg[2:1] == 2'b01);
   assign period_zero = (SYNC_PERIOD == 32'd0);
   assign arm         = SYNC_TIME_VALID && !period_zero;
   assign sys_inc     = sys_time_reg + 64'd1;
   assign lock_time   = cap_reg + 64'(SYNC_LAT);
   assign timeout_inc = timeout_reg + TO_W'(1);
   assign timeout_lim = TO_W'(TO_MULT) * TO_W'(SYNC_PERIOD);

`ifdef SYS_TIME_SLEW_EN
   localparam logic signed [31:0] MAX_ERR_S = 32'(MAX_ERR);

   logic signed [31:0] corr_reg, corr_next;
   logic signed [63:0] err_full;
   logic signed [31:0] err_sat;
   logic               err_small;

   assign err_full = $signed(ref_reg - sys_inc);

   always_comb begin
      if (!err_full[63] && (err_full[62:31] != '0))
         err_sat = 32'sh7FFF_FFFF;
      else if (err_full[63] && (err_full[62:31] != '1))
         err_sat = 32'sh8000_0000;
      else
         err_sat = err_full[31:0];
   end

   assign err_small = (err_sat <= MAX_ERR_S) && (err_sat >= -MAX_ERR_S);
`endif

   always_comb begin
      state_next    = state_reg;
      sys_time_next = sys_inc;
      cap_next      = cap_reg;
      ref_next      = ref_reg;
      timeout_next  = '0;
      jump_next     = 1'b0;
`ifdef SYS_TIME_SLEW_EN
      corr_next     = corr_reg;
`endif
      if (arm) begin
         // A new arm request takes priority over an edge seen in the same cycle.
         state_next = S_ARMED;
         cap_next   = SYNC_TIME;
`ifdef SYS_TIME_SLEW_EN
         corr_next  = '0;
`endif
      end else begin
         case (state_reg)
            S_ARMED: begin
               if (sync_edge) begin
                  sys_time_next = lock_time;
                  ref_next      = lock_time + {32'd0, SYNC_PERIOD};
                  jump_next     = 1'b1;
                  state_next    = S_LOCKED;
               end
            end
            S_LOCKED: begin
               if (period_zero) begin
                  state_next = S_FREE;
`ifdef SYS_TIME_SLEW_EN
                  corr_next  = '0;
`endif
               end else if (sync_edge) begin
                  ref_next = ref_reg + {32'd0, SYNC_PERIOD};
`ifdef SYS_TIME_SLEW_EN
                  // Small errors replace any leftover correction; large ones snap.
                  if (err_small) begin
                     corr_next = err_sat;
                  end else begin
                     sys_time_next = ref_reg;
                     corr_next     = '0;
                     jump_next     = 1'b1;
                  end
`else
                  if (ref_reg != sys_inc) begin
                     sys_time_next = ref_reg;
                     jump_next     = 1'b1;
                  end
`endif
               end else if (timeout_inc >= timeout_lim) begin
                  state_next = S_FREE;
`ifdef SYS_TIME_SLEW_EN
                  corr_next  = '0;
`endif
               end else begin
                  timeout_next = timeout_inc;
`ifdef SYS_TIME_SLEW_EN
                  if (corr_reg > 0) begin
                     sys_time_next = sys_time_reg + 64'd2;
                     corr_next     = corr_reg - 32'sd1;
                  end else if (corr_reg < 0) begin
                     sys_time_next = sys_time_reg;
                     corr_next     = corr_reg + 32'sd1;
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg    <= S_FREE;
         sync_ff_reg  <= '0;
         sys_time_reg <= '0;
         cap_reg      <= '0;
         ref_reg      <= '0;
         timeout_reg  <= '0;
         pulse_reg    <= 1'b0;
         jump_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         sync_ff_reg  <= {sync_ff_reg[1:0], SYNC_IN};
         sys_time_reg <= sys_time_next;
         cap_reg      <= cap_next;
         ref_reg      <= ref_next;
         timeout_reg  <= timeout_next;
         pulse_reg    <= sync_edge;
         jump_reg     <= jump_next;
      end
   end

`ifdef SYS_TIME_SLEW_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         corr_reg <= '0;
      else
         corr_reg <= corr_next;
   end
`endif

   assign SYS_TIME   = sys_time_reg;
   assign LOCKED     = (state_reg == S_LOCKED);
   assign SYNC_PULSE = pulse_reg;
   assign JUMP       = jump_reg;

endmodule

// File: tb/tb_sys_time_sync_gen.sv
// Bench for sys_time_sync_gen: directed lock/drift/timeout cases plus randomized SYNC0 trains.
`timescale 1ns/1ps
module tb_sys_time_sync_gen;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        SYNC_IN;
   logic [63:0] SYNC_TIME;
   logic        SYNC_TIME_VALID;
   logic [31:0] SYNC_PERIOD;
   logic [63:0] SYS_TIME;
   logic        LOCKED;
   logic        SYNC_PULSE;
   logic        JUMP;

   sys_time_sync_gen dut (
      .CLK             (CLK),
      .RST_N           (RST_N),
      .SYNC_IN         (SYNC_IN),
      .SYNC_TIME       (SYNC_TIME),
      .SYNC_TIME_VALID (SYNC_TIME_VALID),
      .SYNC_PERIOD     (SYNC_PERIOD),
      .SYS_TIME        (SYS_TIME),
      .LOCKED          (LOCKED),
      .SYNC_PULSE      (SYNC_PULSE),
      .JUMP            (JUMP)
   );

   always #5 CLK = ~CLK;

   int n_vec  = 0;
   int n_err  = 0;
   int since  = 0;
   int n_rise = 0;

   // Reference model: plain 64-bit arithmetic over the sampled SYNC_IN history.
   localparam int MF = 0, MA = 1, ML = 2;
   int          m_mode;
   logic [63:0] m_time, m_cap, m_ref;
   longint      m_corr, m_to;
   bit          m_pulse, m_jump;
   bit          samp[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode  = MF;
      m_time  = '0;
      m_cap   = '0;
      m_ref   = '0;
      m_corr  = 0;
      m_to    = 0;
      m_pulse = 1'b0;
      m_jump  = 1'b0;
      samp    = '{1'b0, 1'b0, 1'b0, 1'b0};
   endfunction

   function automatic void model_step();
      logic [63:0] nt;
      bit          e, nj;
      longint      err, per;
      if (!RST_N) begin
         model_reset();
         return;
      end
      samp.push_front(SYNC_IN);
      void'(samp.pop_back());
      // a rise sampled two edges ago acts on this edge
      e   = samp[2] && !samp[3];
      per = longint'({32'd0, SYNC_PERIOD});
      nt  = m_time + 64'd1;
      nj  = 1'b0;
      if (SYNC_TIME_VALID && per != 0) begin
         m_mode = MA;
         m_cap  = SYNC_TIME;
         m_corr = 0;
         m_to   = 0;
      end else if (m_mode == ML && per == 0) begin
         m_mode = MF;
         m_corr = 0;
         m_to   = 0;
      end else if (m_mode == MA && e) begin
         nt     = m_cap + 64'd3;
         m_ref  = m_cap + 64'd3 + 64'(per);
         nj     = 1'b1;
         m_mode = ML;
         m_to   = 0;
      end else if (m_mode == ML && e) begin
         err = longint'(m_ref - (m_time + 64'd1));
`ifdef SYS_TIME_SLEW_EN
         if (err >= -64 && err <= 64) begin
            m_corr = err;
         end else begin
            nt     = m_ref;
            m_corr = 0;
            nj     = 1'b1;
         end
`else
         if (err != 0) begin
            nt = m_ref;
            nj = 1'b1;
         end
`endif
         m_ref = m_ref + 64'(per);
         m_to  = 0;
      end else if (m_mode == ML) begin
         m_to = m_to + 1;
         if (m_to >= 2 * per) begin
            m_mode = MF;
            m_corr = 0;
            m_to   = 0;
         end else if (m_corr > 0) begin
            nt     = m_time + 64'd2;
            m_corr = m_corr - 1;
         end else if (m_corr < 0) begin
            nt     = m_time;
            m_corr = m_corr + 1;
         end
      end
      m_time  = nt;
      m_jump  = nj;
      m_pulse = e;
   endfunction

   task automatic cycle();
      @(posedge CLK);
      model_step();
      since++;
      @(negedge CLK);
      chk("sys_time", SYS_TIME, m_time);
      chk("locked", 64'(LOCKED), 64'(m_mode == ML));
      chk("sync_pulse", 64'(SYNC_PULSE), 64'(m_pulse));
      chk("jump", 64'(JUMP), 64'(m_jump));
   endtask

   task automatic run(input int n);
      SYNC_IN = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic rise(input int n);
      n_rise++;
      $display("sync rise %0d: gap %0d, period %0d, SYS_TIME %0d", n_rise, since, SYNC_PERIOD, SYS_TIME);
      SYNC_IN = 1'b1;
      since   = 0;
      for (int i = 0; i < n; i++) begin
         if (i == 2) SYNC_IN = 1'b0;
         cycle();
      end
   endtask

   task automatic run_until(input int gap);
      run(gap - since);
   endtask

   task automatic strobe(input logic [63:0] t);
      SYNC_TIME       = t;
      SYNC_TIME_VALID = 1'b1;
      cycle();
      SYNC_TIME_VALID = 1'b0;
   endtask

   initial begin
      RST_N           = 1'b0;
      SYNC_IN         = 1'b0;
      SYNC_TIME       = '0;
      SYNC_TIME_VALID = 1'b0;
      SYNC_PERIOD     = '0;
      model_reset();

      // reset state and count-up
      run(3);
      chk("rst_sys_time", SYS_TIME, 64'd0);
      chk("rst_locked", 64'(LOCKED), 64'd0);
      chk("rst_pulse", 64'(SYNC_PULSE), 64'd0);
      chk("rst_jump", 64'(JUMP), 64'd0);
      RST_N = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         cycle();
         chk("count_up", SYS_TIME, 64'(i));
      end

      // lock
      SYNC_PERIOD = 32'd1000;
      strobe(64'd5000);
      run(5);
      rise(3);
      chk("t2_time", SYS_TIME, 64'd5003);
      chk("t2_jump", 64'(JUMP), 64'd1);
      chk("t2_locked", 64'(LOCKED), 64'd1);
      chk("t2_pulse", 64'(SYNC_PULSE), 64'd1);

      // slow drift, err=+2
      run_until(998);
      rise(3);
`ifdef SYS_TIME_SLEW_EN
      chk("t3_time", SYS_TIME, 64'd6001);
      chk("t3_nojump", 64'(JUMP), 64'd0);
      run(1);
      chk("t3_slew1", SYS_TIME, 64'd6003);
      run(1);
      chk("t3_slew2", SYS_TIME, 64'd6005);
      run(1);
      chk("t3_settle", SYS_TIME, 64'd6006);
`else
      chk("t6c_time", SYS_TIME, 64'd6003);
      chk("t6c_jump", 64'(JUMP), 64'd1);
`endif

      // fast drift, err=-3
      run_until(1003);
      rise(3);
`ifdef SYS_TIME_SLEW_EN
      chk("t4_time", SYS_TIME, 64'd7006);
      chk("t4_nojump", 64'(JUMP), 64'd0);
      for (int i = 0; i < 3; i++) begin
         run(1);
         chk("t4_hold", SYS_TIME, 64'd7006);
      end
      run(1);
      chk("t4_resume", SYS_TIME, 64'd7007);
`else
      chk("t4_time", SYS_TIME, 64'd7003);
      chk("t4_jump", 64'(JUMP), 64'd1);
`endif

      // big error forces a jump
      run_until(1100);
      rise(3);
      chk("t5_time", SYS_TIME, 64'd8003);
      chk("t5_jump", 64'(JUMP), 64'd1);

      // loss of sync after 2*period cycles without an edge
      run_until(2002);
      chk("t6a_still_locked", 64'(LOCKED), 64'd1);
      run(1);
      chk("t6a_unlocked", 64'(LOCKED), 64'd0);
      chk("t6a_continuous", SYS_TIME, 64'd10003);

      // VALID coincident with an edge: re-arm, no load
      strobe(64'd20000);
      run(3);
      rise(3);
      chk("t6b_lock", SYS_TIME, 64'd20003);
      run_until(1000);
      rise(2);
      SYNC_TIME       = 64'd777;
      SYNC_TIME_VALID = 1'b1;
      run(1);
      SYNC_TIME_VALID = 1'b0;
      chk("t6b_unlocked", 64'(LOCKED), 64'd0);
      chk("t6b_noload", SYS_TIME, 64'd21003);
      chk("t6b_nojump", 64'(JUMP), 64'd0);
      chk("t6b_pulse", 64'(SYNC_PULSE), 64'd1);
      run_until(50);
      rise(3);
      chk("t6b_armed_load", SYS_TIME, 64'd780);
      chk("t6b_armed_jump", 64'(JUMP), 64'd1);

      // reset mid-operation drops a pending arm
      strobe(64'd900);
      run(2);
      RST_N = 1'b0;
      #1;
      model_reset();
      chk("midrst_sys_time", SYS_TIME, 64'd0);
      chk("midrst_locked", 64'(LOCKED), 64'd0);
      chk("midrst_pulse", 64'(SYNC_PULSE), 64'd0);
      chk("midrst_jump", 64'(JUMP), 64'd0);
      run(2);
      RST_N = 1'b1;
      run(1);
      chk("midrst_restart", SYS_TIME, 64'd1);
      rise(3);
      chk("midrst_arm_lost", 64'(LOCKED), 64'd0);
      chk("midrst_count", SYS_TIME, 64'd4);

      // randomized SYNC0 trains, including near-wrap start times
      for (int s = 0; s < 6; s++) begin
         logic [63:0] st;
         int          per, gap, sel;
         per         = int'($urandom_range(100, 200));
         SYNC_PERIOD = 32'(per);
         if (s % 3 == 2)
            st = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 300));
         else
            st = {$urandom, $urandom};
         strobe(st);
         run(int'($urandom_range(3, 10)));
         for (int k = 0; k < 12; k++) begin
            if (m_mode == MF && $urandom_range(0, 1) == 1) strobe({$urandom, $urandom});
            sel = int'($urandom_range(0, 19));
            if (sel < 12)      gap = per + int'($urandom_range(0, 10)) - 5;
            else if (sel < 14) gap = per + int'($urandom_range(66, 90));
            else if (sel < 16) gap = per - int'($urandom_range(66, 90));
            else               gap = 2 * per + int'($urandom_range(1, 20));
            rise(3);
            if (sel == 16) begin
               run(int'($urandom_range(5, 20)));
               strobe({$urandom, $urandom});
            end
            if (sel == 17) begin
               run(5);
               SYNC_PERIOD = 32'd0;
               run(2);
               strobe({$urandom, $urandom});
               SYNC_PERIOD = 32'(per);
               strobe({$urandom, $urandom});
            end
            run_until(gap);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
